// File: rtl/wb_uart.sv
// Wishbone classic slave UART: 8N1 transmitter and receiver with TX/RX FIFOs,
// programmable clocks-per-bit divisor, sticky error flags and a level interrupt.
module wb_uart #(
  parameter logic [15:0] DIV_RESET = 16'd434,
  parameter int          TX_DEPTH  = 16,
  parameter int          RX_DEPTH  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        CYC,
  input  logic        STB,
  input  logic        WE,
  input  logic [31:0] ADR,
  input  logic [31:0] DAT_I,
  output logic [31:0] DAT_O,
  output logic        ACK,
  output logic        ERR,
  output logic        RTY,
  input  logic        rx,
  output logic        tx,
  output logic        irq,
  output logic [1:0]  o_tx_state,
  output logic [1:0]  o_rx_state
);

  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam logic [TAW:0] TX_MAX = TX_DEPTH[TAW:0];
  localparam logic [RAW:0] RX_MAX = RX_DEPTH[RAW:0];

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // Bus side: a strobe is taken only when no termination is currently on the bus.
  logic        r_ack, r_err;
  logic [31:0] r_dat;
  logic [15:0] r_div;
  logic [1:0]  r_ctrl;
  logic        r_overrun, r_frame_err, r_irq;
  logic        w_req, w_sel_data, w_tx_wr, w_bus_err, w_div_wr, w_ctrl_wr, w_clr;
  logic [31:0] w_rdata;

  logic [7:0]   r_tx_mem [TX_DEPTH];
  logic [TAW-1:0] r_tx_wptr, r_tx_rptr;
  logic [TAW:0] r_tx_cnt;
  logic         w_tx_full, w_tx_empty, w_tx_push, w_tx_pop, w_tx_done;

  logic [7:0]   r_rx_mem [RX_DEPTH];
  logic [RAW-1:0] r_rx_wptr, r_rx_rptr;
  logic [RAW:0] r_rx_cnt;
  logic         w_rx_full, w_rx_empty, w_rx_push, w_rx_pop, w_rx_ovr, w_rx_frm;

  state_t      r_tx_state, w_tx_next;
  logic [15:0] r_tx_tick, r_tx_div;
  logic [2:0]  r_tx_bit;
  logic [7:0]  r_tx_shift;
  logic        w_tx_tick_end, w_tx_line;

  state_t      r_rx_state, w_rx_next;
  logic [15:0] r_rx_tick, r_rx_div;
  logic [2:0]  r_rx_bit;
  logic [7:0]  r_rx_shift;
  logic        r_rx_meta, r_rx_sync, r_rx_prev;
  logic        w_rx_fall, w_rx_tick_end, w_rx_half_end, w_rx_stop;

  logic w_unused;
  assign w_unused = &{1'b0, ADR[31:4], ADR[1:0], DAT_I[31:16]};

  assign w_req      = CYC & STB & ~(r_ack | r_err);
  assign w_sel_data = (ADR[3:2] == 2'd0);
  assign w_tx_wr    = w_req & WE & w_sel_data;
  assign w_tx_push  = w_tx_wr & (~w_tx_full | w_tx_pop);
  assign w_bus_err  = w_tx_wr & w_tx_full & ~w_tx_pop;
  assign w_rx_pop   = w_req & ~WE & w_sel_data & ~w_rx_empty;
  assign w_div_wr   = w_req & WE & (ADR[3:2] == 2'd2);
  assign w_ctrl_wr  = w_req & WE & (ADR[3:2] == 2'd3);
  assign w_clr      = w_ctrl_wr & DAT_I[7];

  assign w_tx_full  = (r_tx_cnt == TX_MAX);
  assign w_tx_empty = (r_tx_cnt == '0);
  assign w_rx_full  = (r_rx_cnt == RX_MAX);
  assign w_rx_empty = (r_rx_cnt == '0);
  assign w_tx_done  = w_tx_empty & (r_tx_state == S_IDLE);

  always_comb begin
    w_rdata = '0;
    case (ADR[3:2])
      2'd0: if (!w_rx_empty) w_rdata = {24'b0, r_rx_mem[r_rx_rptr]};
      2'd1: w_rdata = {26'b0, r_frame_err, r_overrun, w_rx_full, w_rx_empty, w_tx_full, w_tx_done};
      2'd2: w_rdata = {16'b0, r_div};
      2'd3: w_rdata = {30'b0, r_ctrl};
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      r_dat <= '0;
    end else begin
      r_ack <= w_req & ~w_bus_err;
      r_err <= w_bus_err;
      r_dat <= (w_req & ~WE) ? w_rdata : '0;
    end
  end

  // A flag set in the same cycle as a clear-write is kept so the event is not lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div       <= DIV_RESET;
      r_ctrl      <= 2'b00;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
      r_irq       <= 1'b0;
    end else begin
      if (w_div_wr) r_div <= (DAT_I[15:0] < 16'd4) ? 16'd4 : DAT_I[15:0];
      if (w_ctrl_wr) r_ctrl <= DAT_I[1:0];
      r_overrun   <= w_rx_ovr | (r_overrun & ~w_clr);
      r_frame_err <= w_rx_frm | (r_frame_err & ~w_clr);
      r_irq       <= (r_ctrl[0] & ~w_rx_empty) | (r_ctrl[1] & w_tx_done);
    end
  end

  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wptr] <= DAT_I[7:0];
    if (w_rx_push) r_rx_mem[r_rx_wptr] <= r_rx_shift;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_wptr <= '0;
      r_tx_rptr <= '0;
      r_tx_cnt  <= '0;
      r_rx_wptr <= '0;
      r_rx_rptr <= '0;
      r_rx_cnt  <= '0;
    end else begin
      if (w_tx_push) r_tx_wptr <= r_tx_wptr + 1'b1;
      if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + 1'b1;
      if (w_tx_push & ~w_tx_pop)      r_tx_cnt <= r_tx_cnt + 1'b1;
      else if (~w_tx_push & w_tx_pop) r_tx_cnt <= r_tx_cnt - 1'b1;
      if (w_rx_push) r_rx_wptr <= r_rx_wptr + 1'b1;
      if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + 1'b1;
      if (w_rx_push & ~w_rx_pop)      r_rx_cnt <= r_rx_cnt + 1'b1;
      else if (~w_rx_push & w_rx_pop) r_rx_cnt <= r_rx_cnt - 1'b1;
    end
  end

  // Transmitter: the divisor is captured whenever a byte is loaded, so a new
  // DIVISOR never changes a frame already on the line.
  assign w_tx_tick_end = (r_tx_tick == r_tx_div - 16'd1);
  assign w_tx_pop = ~w_tx_empty &
                    ((r_tx_state == S_IDLE) | ((r_tx_state == S_STOP) & w_tx_tick_end));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_state <= S_IDLE;
      r_tx_tick  <= '0;
      r_tx_div   <= DIV_RESET;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
    end else begin
      r_tx_state <= w_tx_next;
      if (w_tx_pop) begin
        r_tx_shift <= r_tx_mem[r_tx_rptr];
        r_tx_div   <= r_div;
        r_tx_tick  <= '0;
        r_tx_bit   <= '0;
      end else if (r_tx_state != S_IDLE) begin
        if (w_tx_tick_end) begin
          r_tx_tick <= '0;
          if (r_tx_state == S_DATA) begin
            r_tx_shift <= r_tx_shift >> 1;
            r_tx_bit   <= r_tx_bit + 3'd1;
          end
        end else begin
          r_tx_tick <= r_tx_tick + 16'd1;
        end
      end
    end
  end

  always_comb begin
    w_tx_next = r_tx_state;
    case (r_tx_state)
      S_IDLE:  if (!w_tx_empty) w_tx_next = S_START;
      S_START: if (w_tx_tick_end) w_tx_next = S_DATA;
      S_DATA:  if (w_tx_tick_end && r_tx_bit == 3'd7) w_tx_next = S_STOP;
      S_STOP:  if (w_tx_tick_end) w_tx_next = w_tx_empty ? S_IDLE : S_START;
    endcase
  end

  always_comb begin
    w_tx_line = 1'b1;
    case (r_tx_state)
      S_START: w_tx_line = 1'b0;
      S_DATA:  w_tx_line = r_tx_shift[0];
      default: w_tx_line = 1'b1;
    endcase
  end

  // Receiver: only the synchronized copy of rx is used; a start needs a high-to-low
  // transition, so after a bad stop bit the line must return high first.
  assign w_rx_fall     = r_rx_prev & ~r_rx_sync;
  assign w_rx_tick_end = (r_rx_tick == r_rx_div - 16'd1);
  assign w_rx_half_end = (r_rx_tick == (r_rx_div >> 1) - 16'd1);
  assign w_rx_stop     = (r_rx_state == S_STOP) & w_rx_tick_end;
  assign w_rx_push     = w_rx_stop & r_rx_sync & (~w_rx_full | w_rx_pop);
  assign w_rx_ovr      = w_rx_stop & r_rx_sync & w_rx_full & ~w_rx_pop;
  assign w_rx_frm      = w_rx_stop & ~r_rx_sync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_meta  <= 1'b1;
      r_rx_sync  <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rx_state <= S_IDLE;
      r_rx_tick  <= '0;
      r_rx_div   <= DIV_RESET;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
    end else begin
      r_rx_meta  <= rx;
      r_rx_sync  <= r_rx_meta;
      r_rx_prev  <= r_rx_sync;
      r_rx_state <= w_rx_next;
      case (r_rx_state)
        S_IDLE: if (w_rx_fall) begin
          r_rx_tick <= '0;
          r_rx_div  <= r_div;
          r_rx_bit  <= '0;
        end
        S_START: r_rx_tick <= w_rx_half_end ? 16'd0 : r_rx_tick + 16'd1;
        S_DATA: if (w_rx_tick_end) begin
          r_rx_tick  <= '0;
          r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
          r_rx_bit   <= r_rx_bit + 3'd1;
        end else begin
          r_rx_tick <= r_rx_tick + 16'd1;
        end
        S_STOP: r_rx_tick <= w_rx_tick_end ? 16'd0 : r_rx_tick + 16'd1;
      endcase
    end
  end

  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      S_IDLE:  if (w_rx_fall) w_rx_next = S_START;
      S_START: if (w_rx_half_end) w_rx_next = r_rx_sync ? S_IDLE : S_DATA;
      S_DATA:  if (w_rx_tick_end && r_rx_bit == 3'd7) w_rx_next = S_STOP;
      S_STOP:  if (w_rx_tick_end) w_rx_next = S_IDLE;
    endcase
  end

  assign tx         = w_tx_line;
  assign DAT_O      = r_dat;
  assign ACK        = r_ack;
  assign ERR        = r_err;
  assign RTY        = 1'b0;
  assign irq        = r_irq;
  assign o_tx_state = r_tx_state;
  assign o_rx_state = r_rx_state;

endmodule

// File: tb/tb_wb_uart.sv
// Bench for wb_uart: bus tasks, serial drivers, a tx line monitor against a byte
// queue model, an rx byte queue model with sticky flags, and a summary report.
module tb_wb_uart;
  localparam logic [15:0] DIV_RST = 16'd10;
  localparam int DEPTH = 16;

  logic        clk, rst, CYC, STB, WE, rx;
  logic [31:0] ADR, DAT_I, DAT_O;
  logic        ACK, ERR, RTY, tx, irq;
  logic [1:0]  tx_state, rx_state;

  wb_uart #(.DIV_RESET(DIV_RST), .TX_DEPTH(DEPTH), .RX_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .CYC(CYC), .STB(STB), .WE(WE), .ADR(ADR),
    .DAT_I(DAT_I), .DAT_O(DAT_O), .ACK(ACK), .ERR(ERR), .RTY(RTY),
    .rx(rx), .tx(tx), .irq(irq), .o_tx_state(tx_state), .o_rx_state(rx_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  bit m_ovr = 0;
  bit m_frm = 0;
  int mon_div = DIV_RST;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // driver tasks: called and returning at 1 time unit after a rising edge
  task automatic bus(input bit we, input logic [1:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output bit err);
    bit to;
    CYC = 1'b1; STB = 1'b1; WE = we; ADR = {28'b0, a, 2'b00}; DAT_I = d;
    to = 1'b1;
    rd = '0; err = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (ACK || ERR) begin to = 1'b0; break; end
    end
    rd = DAT_O; err = ERR;
    if (to) begin
      checks++; errors++;
      $display("FAIL bus_timeout adr=%0d no termination within 16 cycles", a);
    end
    @(posedge clk); #1;
    CYC = 1'b0; STB = 1'b0; WE = 1'b0;
    check("term_one_cycle", {30'b0, ACK, ERR}, 32'h0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d, input bit exp_err);
    logic [31:0] rd; bit err;
    bus(1'b1, a, d, rd, err);
    check("wr_err", {31'b0, err}, {31'b0, exp_err});
    if (a == 2'd0 && !exp_err) exp_q.push_back(d[7:0]);
    if (a == 2'd2) mon_div = (d[15:0] < 16'd4) ? 4 : int'(d[15:0]);
  endtask

  task automatic rd_chk(input string nm, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] rd; bit err;
    bus(1'b0, a, 32'h0, rd, err);
    check(nm, rd, exp);
  endtask

  function automatic logic [31:0] exp_status();
    return {26'b0, m_frm, m_ovr, rx_q.size() == DEPTH, rx_q.size() == 0, 1'b0, 1'b1};
  endfunction

  task automatic rd_data_model();
    logic [31:0] e;
    e = (rx_q.size() > 0) ? {24'b0, rx_q.pop_front()} : 32'h0;
    rd_chk("rx_data", 2'd0, e);
  endtask

  task automatic send_rx(input logic [7:0] b, input int d, input bit stop_ok);
    rx = 1'b0; cyc(d);
    for (int i = 0; i < 8; i++) begin rx = b[i]; cyc(d); end
    rx = stop_ok; cyc(d);
    if (!stop_ok) begin
      rx = 1'b1; cyc(2 * d);
      m_frm = 1'b1;
    end else if (rx_q.size() < DEPTH) rx_q.push_back(b);
    else m_ovr = 1'b1;
  endtask

  // scoreboard: tx line monitor checks every bit of every frame against exp_q
  bit mon_active = 0, mon_b2b = 0, mon_chk = 0, mon_bad = 0;
  int mon_k = 0, mon_d = 1, mon_frames = 0;
  logic [7:0] mon_byte = 0;

  always @(negedge clk) begin
    int b;
    logic eb;
    if (!rst) begin
      mon_active = 0; mon_b2b = 0;
    end else begin
      checks++;
      if (RTY !== 1'b0 || (ACK & ERR) === 1'b1) begin
        errors++;
        $display("FAIL bus_lines RTY=%b ACK=%b ERR=%b", RTY, ACK, ERR);
      end
      if (!mon_active && mon_b2b) check("tx_no_gap", {31'b0, tx}, 32'h0);
      mon_b2b = 0;
      if (!mon_active && tx === 1'b0) begin
        mon_active = 1; mon_k = 0; mon_bad = 0; mon_d = mon_div; mon_frames++;
        if (exp_q.size() == 0) begin
          checks++; errors++; mon_chk = 0;
          $display("FAIL tx_unexpected_frame actual=start_bit expected=idle");
        end else begin
          mon_chk = 1; mon_byte = exp_q.pop_front();
        end
      end
      if (mon_active) begin
        b = mon_k / mon_d;
        eb = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : mon_byte[b-1];
        if (tx !== eb) mon_bad = 1;
        if (mon_k % mon_d == mon_d - 1) begin
          if (mon_chk) begin
            checks++;
            if (mon_bad) begin
              errors++;
              $display("FAIL tx_bit byte=%h bit=%0d actual=not_steady expected=%b", mon_byte, b, eb);
            end
          end
          mon_bad = 0;
        end
        mon_k++;
        if (mon_k == 10 * mon_d) begin
          mon_active = 0;
          mon_b2b = (exp_q.size() > 0);
        end
      end
    end
  end

  task automatic wait_tx_idle(input int bound);
    bit done = 0;
    for (int i = 0; i < bound; i++) begin
      if (exp_q.size() == 0 && !mon_active) begin done = 1; break; end
      @(negedge clk);
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL tx_drain_timeout pending=%0d expected=0", exp_q.size());
    end
    cyc(3);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    exp_q.delete(); rx_q.delete();
    m_ovr = 0; m_frm = 0; mon_div = DIV_RST;
    check("rst_tx", {31'b0, tx}, 32'h1);
    check("rst_ack_err", {30'b0, ACK, ERR}, 32'h0);
    check("rst_rty", {31'b0, RTY}, 32'h0);
    check("rst_dat_o", DAT_O, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    cyc(2);
  endtask

  initial begin
    int f0, dv, n;
    logic [7:0] bv;
    logic [31:0] rd;
    bit err;
    rst = 1'b1; CYC = 0; STB = 0; WE = 0; ADR = 0; DAT_I = 0; rx = 1'b1;
    #3;
    do_reset();
    rd_chk("rst_status", 2'd1, 32'h5);
    rd_chk("rst_divisor", 2'd2, {16'b0, DIV_RST});
    rd_chk("rst_ctrl", 2'd3, 32'h0);
    rd_chk("rst_data_empty", 2'd0, 32'h0);

    // single frame 0x55 at divisor 8
    wr(2'd2, 32'd8, 0);
    rd_chk("div8", 2'd2, 32'd8);
    wr(2'd0, 32'h55, 0);
    wait_tx_idle(400);
    rd_chk("tx_empty_after_55", 2'd1, 32'h5);

    // clamp and back-to-back fill at divisor 4
    wr(2'd2, 32'd2, 0);
    rd_chk("div_clamp", 2'd2, 32'd4);
    f0 = mon_frames;
    for (int i = 0; i < 17; i++) wr(2'd0, $urandom_range(0, 255), 0);
    wr(2'd0, 32'hEE, 1);
    bus(1'b0, 2'd1, 0, rd, err);
    check("status_tx_full", rd, 32'h6);
    wait_tx_idle(2000);
    check("tx_frame_count", mon_frames - f0, 32'd17);

    // interrupt enables and CTRL readback
    wr(2'd3, 32'h2, 0);
    cyc(1);
    check("irq_tx_empty", {31'b0, irq}, 32'h1);
    wr(2'd3, 32'h81, 0);
    cyc(1);
    check("irq_rx_empty", {31'b0, irq}, 32'h0);
    rd_chk("ctrl_rb", 2'd3, 32'h1);

    // one received byte 0xA3 at divisor 8
    wr(2'd2, 32'd8, 0);
    send_rx(8'hA3, 8, 1);
    cyc(6);
    rd_chk("status_rx_avail", 2'd1, exp_status());
    check("irq_rx", {31'b0, irq}, 32'h1);
    rd_chk("rx_a3", 2'd0, 32'h000000A3);
    void'(rx_q.pop_front());
    rd_chk("rx_empty_read", 2'd0, 32'h0);
    rd_chk("status_rx_drained", 2'd1, 32'h5);

    // overrun: 17 frames with no reads
    for (int i = 0; i < 17; i++) send_rx(8'($urandom_range(0, 255)), 8, 1);
    cyc(6);
    rd_chk("status_overrun", 2'd1, exp_status());
    for (int i = 0; i < 17; i++) rd_data_model();
    wr(2'd3, 32'h80, 0);
    m_ovr = 0;
    rd_chk("ovr_cleared", 2'd1, exp_status());

    // glitch then bad stop bit
    rx = 1'b0; cyc(2); rx = 1'b1; cyc(30);
    rd_chk("glitch_nothing", 2'd1, exp_status());
    send_rx(8'h3C, 8, 0);
    rd_chk("frame_err", 2'd1, exp_status());
    rd_chk("frame_err_no_byte", 2'd0, 32'h0);
    wr(2'd3, 32'h80, 0);
    m_frm = 0;
    rd_chk("frm_cleared", 2'd1, exp_status());

    // randomized traffic at random divisors
    for (int it = 0; it < 6; it++) begin
      dv = $urandom_range(4, 12);
      wr(2'd2, dv, 0);
      n = $urandom_range(1, 4);
      for (int j = 0; j < n; j++) wr(2'd0, $urandom_range(0, 255), 0);
      wait_tx_idle(12 * 10 * 5);
      n = $urandom_range(1, 3);
      for (int j = 0; j < n; j++) begin
        bv = 8'($urandom_range(0, 255));
        send_rx(bv, dv, 1);
      end
      cyc(dv + 4);
      rd_chk("rand_status", 2'd1, exp_status());
      for (int j = 0; j <= n; j++) rd_data_model();
    end

    // reset in the middle of a tx frame and an rx frame
    wr(2'd3, 32'h1, 0);
    wr(2'd2, 32'd8, 0);
    wr(2'd0, 32'hC6, 0);
    cyc(20);
    rx = 1'b0; cyc(8); rx = 1'b1; cyc(8);
    do_reset();
    rd_chk("post_rst_status", 2'd1, 32'h5);
    rd_chk("post_rst_div", 2'd2, {16'b0, DIV_RST});
    wr(2'd0, 32'h3E, 0);
    wait_tx_idle(400);
    send_rx(8'h81, int'(DIV_RST), 1);
    cyc(8);
    rd_data_model();

    cyc(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #800000;
    errors++;
    $display("FAIL watchdog actual=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
